// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for load-use, branch redirect and multi-cycle data memory
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ready,
  input  logic             err_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic memop, timeout, done, mstall, load_use;
  assign memop    = mem_read | mem_write;
  assign timeout  = (state == WAIT) & (wait_cnt == 16'(TIMEOUT - 1)) & ~dmem_ready;
  assign done     = memop & (dmem_ready | timeout);
  assign mstall   = memop & ~done;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // Outputs are forced low while reset is asserted, independent of the clock.
  assign pc_en        = rst_n & ~mstall & (ex_branch_taken | ~load_use);
  assign if_id_en     = pc_en;
  assign if_id_flush  = rst_n & ~mstall & ex_branch_taken;
  assign id_ex_en     = rst_n & ~mstall;
  assign id_ex_flush  = rst_n & ~mstall & (ex_branch_taken | load_use);
  assign ex_mem_en    = rst_n & ~mstall;
  assign ex_mem_flush = 1'b0;
  assign mem_wb_en    = rst_n;
  assign mem_wb_flush = rst_n & mstall;
  assign dmem_req     = rst_n & memop;
  assign mem_err      = rst_n & memop & timeout;
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (state == IDLE) begin
      state_nxt    = (memop & ~dmem_ready) ? WAIT : IDLE;
      wait_cnt_nxt = 16'd0;
    end else begin
      state_nxt    = (~memop | dmem_ready | timeout) ? IDLE : WAIT;
      wait_cnt_nxt = (~memop | dmem_ready | timeout) ? 16'd0 : wait_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      err_sticky   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      err_sticky   <= mem_err | (err_sticky & ~err_clr);
      stall_cycles <= pc_en ? stall_cycles : stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-level behavioural model of the hazard rules
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic mem_read = 0, mem_write = 0, dmem_ready = 0, err_clr = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic mem_wb_en, mem_wb_flush, dmem_req, mem_err, err_sticky;
  logic [CW-1:0] stall_cycles;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready), .err_clr(err_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .dmem_req(dmem_req), .mem_err(mem_err), .err_sticky(err_sticky), .stall_cycles(stall_cycles)
  );
  typedef struct {
    logic rst_n;
    logic [4:0] rs1, rs2, exrd;
    logic u1, u2, exmr, br, mr, mw, rdy, clr;
  } stim_t;
  typedef struct {
    logic [10:0] ctl;
    logic [CW-1:0] stall;
    logic sticky;
    int cyc;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_waited = 0;
  int m_stall = 0;
  bit m_sticky = 0;
  function automatic stim_t nop();
    stim_t s;
    s = '{rst_n: 1'b1, rs1: 5'd0, rs2: 5'd0, exrd: 5'd0, u1: 1'b0, u2: 1'b0,
          exmr: 1'b0, br: 1'b0, mr: 1'b0, mw: 1'b0, rdy: 1'b0, clr: 1'b0};
    return s;
  endfunction
  // ctl order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, req, err
  task automatic step(input stim_t s);
    exp_t e;
    bit memop, to, done, ms, lu, pc;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.exrd;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; ex_mem_read = s.exmr; ex_branch_taken = s.br;
    mem_read = s.mr; mem_write = s.mw; dmem_ready = s.rdy; err_clr = s.clr;
    cyc++;
    e.cyc = cyc;
    if (!s.rst_n) begin
      m_waited = 0; m_stall = 0; m_sticky = 0;
      e.ctl = '0; e.stall = '0; e.sticky = 1'b0;
      q.push_back(e);
      return;
    end
    memop = s.mr | s.mw;
    to    = memop && !s.rdy && (m_waited == TO);
    done  = memop && (s.rdy || to);
    ms    = memop && !done;
    lu    = s.exmr && (s.exrd != 0) && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
    if (ms)        e.ctl = 11'b00000001100;
    else if (s.br) e.ctl = 11'b11111101000;
    else if (lu)   e.ctl = 11'b00011101000;
    else           e.ctl = 11'b11010101000;
    e.ctl[1] = memop;
    e.ctl[0] = to;
    e.stall  = CW'(m_stall);
    e.sticky = m_sticky;
    q.push_back(e);
    pc = e.ctl[10];
    if (!pc) m_stall = (m_stall + 1) % (1 << CW);
    m_sticky = to || (m_sticky && !s.clr);
    m_waited = ms ? m_waited + 1 : 0;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e = q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
             mem_wb_en, mem_wb_flush, dmem_req, mem_err};
      checks += 3;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctl);
      end
      if (stall_cycles !== e.stall) begin
        errors++;
        $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cycles, e.stall);
      end
      if (err_sticky !== e.sticky) begin
        errors++;
        $display("FAIL err_sticky cyc=%0d got=%b exp=%b", e.cyc, err_sticky, e.sticky);
      end
    end
  end
  initial begin
    stim_t s, lu_s;
    s = nop(); s.rst_n = 1'b0;
    repeat (2) step(s);
    step(nop());
    lu_s = nop(); lu_s.exmr = 1; lu_s.exrd = 5'd5; lu_s.rs1 = 5'd5; lu_s.u1 = 1;
    step(lu_s);
    step(nop());
    s = lu_s; s.br = 1;
    step(s);
    step(nop());
    s = nop(); s.mr = 1; s.rdy = 1;
    step(s);
    step(nop());
    s = nop(); s.mw = 1;
    repeat (3) step(s);
    s.rdy = 1;
    step(s);
    step(nop());
    s = nop(); s.mr = 1;
    repeat (5) step(s);
    repeat (2) step(nop());
    s = nop(); s.clr = 1;
    step(s);
    step(nop());
    s = nop(); s.mr = 1;
    repeat (4) step(s);
    s.clr = 1;
    step(s);
    step(nop());
    s = nop(); s.mr = 1;
    repeat (2) step(s);
    s.rst_n = 0;
    step(s);
    step(nop());
    repeat (260) step(lu_s);
    step(nop());
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.exrd  = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom);
      s.u2    = 1'($urandom);
      s.exmr  = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.mr    = ($urandom_range(0, 3) == 0);
      s.mw    = ($urandom_range(0, 4) == 0);
      s.rdy   = ($urandom_range(0, 2) == 0);
      s.clr   = ($urandom_range(0, 9) == 0);
      step(s);
    end
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core. It produces the enable/flush pairs for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable. It resolves three conditions:
- load-use hazards;
- taken-branch redirects;
- multi-cycle data-memory accesses, via a req/ready handshake with timeout.
It sits beside the datapath, reads the control fields held in the pipeline registers, and exports a stall-cycle performance counter.

Parameters:
TIMEOUT, 64, max WAIT cycles before a data access is abandoned (2..65535)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 address of instruction in ID
id_rs2  in  5  rs2 address of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd held in ID/EX
ex_mem_read  in  1  ID/EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_read  in  1  EX/MEM mem_read_out
mem_write  in  1  EX/MEM mem_write_out
dmem_ready  in  1  data memory completes current access this cycle
err_clr  in  1  clears err_sticky
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID enable
if_id_flush  out  1  IF/ID flush
id_ex_en  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX flush
ex_mem_en  out  1  EX/MEM enable
ex_mem_flush  out  1  EX/MEM flush
mem_wb_en  out  1  MEM/WB enable
mem_wb_flush  out  1  MEM/WB flush
dmem_req  out  1  data access request
mem_err  out  1  one-cycle pulse on access timeout
err_sticky  out  1  latched timeout flag
stall_cycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- Reset (rst_n low, async): state=IDLE, wait_cnt=0, err_sticky=0, stall_cycles=0. All enables, flushes, dmem_req and mem_err are 0 while rst_n is low.
- Pipeline registers give flush priority over enable. This block therefore never asserts a flush on a register it is freezing.
- memop = mem_read | mem_write.
- done = memop & (dmem_ready | timeout). timeout = (state==WAIT) & (wait_cnt==TIMEOUT-1) & ~dmem_ready.
- mstall = memop & ~done.

Data-memory FSM, states IDLE and WAIT:
- dmem_req = memop in both states. It is combinational and held until done.
- IDLE: memop & ~dmem_ready -> WAIT, wait_cnt=0. memop & dmem_ready is a zero-wait access, stay IDLE.
- WAIT: dmem_ready -> IDLE. timeout -> IDLE, mem_err=1 for that cycle, err_sticky=1. Otherwise wait_cnt+1.
- memop dropping while in WAIT is not legal. It is still handled by returning to IDLE.

Priority (highest first), evaluated combinationally each cycle:
- mstall: pc_en=if_id_en=id_ex_en=ex_mem_en=0. mem_wb_en=1 with mem_wb_flush=1 (bubble into WB). All other flushes 0. Branch and load-use are ignored, since ID/EX is frozen and they re-evaluate later.
- ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1. Branch overrides load-use, because the stalled instruction is squashed anyway.
- Load-use: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Outputs: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
- Otherwise: all enables 1, all flushes 0.

Other rules:
- ex_mem_flush is 0 in every case. It is reserved and tied low.
- stall_cycles increments each cycle pc_en=0 (rst_n high), with wrap-around modulo 2^CNT_W.
- err_sticky clears on err_clr. A timeout coincident with err_clr sets it, because set wins.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; stall_cycles 0->1.
- Branch + load-use same cycle: ex_branch_taken=1 with the hazard above -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- Zero-wait load: mem_read=1, dmem_ready=1 same cycle -> dmem_req=1, all enables 1, state stays IDLE.
- 3-wait store: mem_write=1, dmem_ready low for 3 cycles then high -> stages frozen 3 cycles, mem_wb_flush=1 those cycles, advance on 4th; stall_cycles=3.
- Timeout (TIMEOUT=4): mem_read=1, dmem_ready never -> mem_err pulses on 5th request cycle, pipeline advances, err_sticky=1 until err_clr.
- Reset mid-WAIT: rst_n low during WAIT -> dmem_req=0 immediately, state IDLE, counters 0, err_sticky 0.
